// File: rtl/taxel_mux_scan_seq.sv
// Taxel mux scan sequencer: steps mux_config over a channel range with a dwell per channel; break-before-make gap when TAXEL_SCAN_BBM_EN is defined.
// Latency: registered outputs, first code one cycle after start; no backpressure, stop returns to IDLE on the next cycle.
module taxel_mux_scan_seq #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [4:0]         first_ch,
  input  logic [4:0]         last_ch,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [2:0]         bbm,
  input  logic               continuous,
  input  logic [1:0]         test_sel,
  output logic [4:0]         mux_config,
  output logic               busy,
  output logic               ch_valid,
  output logic               ch_done,
  output logic               scan_done,
  output logic               cfg_err
);

  localparam logic [4:0]         CODE_OFF   = 5'd25;
  localparam logic [4:0]         LAST_LEGAL = 5'd24;
  localparam logic [DWELL_W-1:0] DW_ONE     = {{(DWELL_W-1){1'b0}}, 1'b1};

  typedef struct packed {
    logic [4:0]         first_ch;
    logic [4:0]         last_ch;
    logic [DWELL_W-1:0] dwell;
`ifdef TAXEL_SCAN_BBM_EN
    logic [2:0]         bbm;
`endif
    logic               continuous;
    logic [1:0]         test_sel;
  } cfg_t;

`ifdef TAXEL_SCAN_BBM_EN
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BREAK} state_t;
  logic [2:0] bcnt_q, bcnt_d;
`else
  typedef enum logic [1:0] {S_IDLE, S_DWELL} state_t;
  logic       unused_bbm;
  assign unused_bbm = ^bbm;
`endif

  state_t             state_q, state_d;
  cfg_t               cfg_q, cfg_d;
  logic [4:0]         ch_q, ch_d;
  logic [DWELL_W-1:0] dcnt_q, dcnt_d;
  logic [DWELL_W-1:0] eff_dwell;
  logic [4:0]         mux_config_q, mux_config_d;
  logic               busy_q, busy_d, ch_valid_q, ch_valid_d;
  logic               ch_done_q, ch_done_d, scan_done_q, scan_done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               go_ch, go_dwell;

  assign eff_dwell = (cfg_d.dwell == '0) ? DW_ONE : cfg_d.dwell;

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    ch_d         = ch_q;
    dcnt_d       = dcnt_q;
`ifdef TAXEL_SCAN_BBM_EN
    bcnt_d       = bcnt_q;
`endif
    mux_config_d = '0;
    busy_d       = 1'b0;
    ch_valid_d   = 1'b0;
    ch_done_d    = 1'b0;
    scan_done_d  = 1'b0;
    cfg_err_d    = 1'b0;
    go_ch        = 1'b0;
    go_dwell     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          cfg_d.first_ch   = first_ch;
          cfg_d.last_ch    = last_ch;
          cfg_d.dwell      = dwell;
`ifdef TAXEL_SCAN_BBM_EN
          cfg_d.bbm        = bbm;
`endif
          cfg_d.continuous = continuous;
          cfg_d.test_sel   = test_sel;
          // Test codes bypass the range check entirely.
          if (!test_sel[1] && ((last_ch > LAST_LEGAL) || (first_ch > last_ch))) begin
            cfg_err_d = 1'b1;
          end else begin
            ch_d  = first_ch;
            go_ch = 1'b1;
          end
        end
      end
`ifdef TAXEL_SCAN_BBM_EN
      S_BREAK: begin
        if (bcnt_q != 3'd0) begin
          bcnt_d       = bcnt_q - 3'd1;
          mux_config_d = CODE_OFF;
          busy_d       = 1'b1;
        end else begin
          go_dwell = 1'b1;
        end
      end
`endif
      S_DWELL: begin
        if (cfg_q.test_sel[1]) begin
          mux_config_d = {4'b1111, cfg_q.test_sel[0]};
          busy_d       = 1'b1;
          ch_valid_d   = 1'b1;
        end else if (dcnt_q != '0) begin
          dcnt_d       = dcnt_q - DW_ONE;
          mux_config_d = ch_q;
          busy_d       = 1'b1;
          ch_valid_d   = 1'b1;
          ch_done_d    = (dcnt_q == DW_ONE);
          scan_done_d  = ch_done_d && (ch_q == cfg_q.last_ch) && !cfg_q.continuous;
        end else if (ch_q != cfg_q.last_ch) begin
          ch_d  = ch_q + 5'd1;
          go_ch = 1'b1;
        end else if (cfg_q.continuous) begin
          ch_d  = cfg_q.first_ch;
          go_ch = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Start of a channel: optional all-off gap, then dwell.
    if (go_ch) begin
`ifdef TAXEL_SCAN_BBM_EN
      if (cfg_d.bbm != 3'd0) begin
        state_d      = S_BREAK;
        bcnt_d       = cfg_d.bbm - 3'd1;
        mux_config_d = CODE_OFF;
        busy_d       = 1'b1;
      end else begin
        go_dwell = 1'b1;
      end
`else
      go_dwell = 1'b1;
`endif
    end

    if (go_dwell) begin
      state_d    = S_DWELL;
      busy_d     = 1'b1;
      ch_valid_d = 1'b1;
      if (cfg_d.test_sel[1]) begin
        mux_config_d = {4'b1111, cfg_d.test_sel[0]};
      end else begin
        mux_config_d = ch_d;
        dcnt_d       = eff_dwell - DW_ONE;
        ch_done_d    = (eff_dwell == DW_ONE);
        scan_done_d  = ch_done_d && (ch_d == cfg_d.last_ch) && !cfg_d.continuous;
      end
    end

    if (stop && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      mux_config_d = '0;
      busy_d       = 1'b0;
      ch_valid_d   = 1'b0;
      ch_done_d    = 1'b0;
      scan_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cfg_q        <= '0;
      ch_q         <= '0;
      dcnt_q       <= '0;
`ifdef TAXEL_SCAN_BBM_EN
      bcnt_q       <= '0;
`endif
      mux_config_q <= '0;
      busy_q       <= 1'b0;
      ch_valid_q   <= 1'b0;
      ch_done_q    <= 1'b0;
      scan_done_q  <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      ch_q         <= ch_d;
      dcnt_q       <= dcnt_d;
`ifdef TAXEL_SCAN_BBM_EN
      bcnt_q       <= bcnt_d;
`endif
      mux_config_q <= mux_config_d;
      busy_q       <= busy_d;
      ch_valid_q   <= ch_valid_d;
      ch_done_q    <= ch_done_d;
      scan_done_q  <= scan_done_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  assign mux_config = mux_config_q;
  assign busy       = busy_q;
  assign ch_valid   = ch_valid_q;
  assign ch_done    = ch_done_q;
  assign scan_done  = scan_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: doc/taxel_mux_scan_seq.md
# taxel_mux_scan_seq

Sequencer that drives the 5-bit `mux_config` code into the taxel one-hot mux encoder. It steps the local POSFET across a programmed range of hem channels (0–24), holds each channel for a programmable dwell, and optionally inserts a break-before-make all-off interval between channels. It also holds either test-source code until stopped. It sits directly upstream of the one-hot encoder inside each taxel logic slice.

## Interface
Parameters:
- `DWELL_W`, 8: width of the dwell counter and `dwell` input.

Ports:
- `clk` in 1: single clock for the block.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: single-cycle request to begin a scan. Honoured only in IDLE.
- `stop` in 1: abort request. Honoured in any state.
- `first_ch` in 5: first channel of the scan range.
- `last_ch` in 5: last channel of the scan range.
- `dwell` in DWELL_W: cycles per channel. A value of 0 is treated as 1.
- `bbm` in 3: all-off cycles inserted before each channel.
- `continuous` in 1: wrap from `last_ch` back to `first_ch` until stopped.
- `test_sel` in 2: selects the mode.
  - 00: scan.
  - 10: test + local, code 30.
  - 11: test only, code 31.
  - 01: reserved, treated as 00.
- `mux_config` out 5: code to the encoder.
- `busy` out 1: high in any state other than IDLE.
- `ch_valid` out 1: high while a channel or test code is stable in DWELL.
- `ch_done` out 1: one-cycle pulse on the final dwell cycle of each scanned channel.
- `scan_done` out 1: one-cycle pulse when a non-continuous scan completes.
- `cfg_err` out 1: one-cycle pulse when a start request has an illegal range.

## Operation
- All outputs are registered.
- Reset values:
  - `mux_config` = 5'd0 (local taxel).
  - `busy`, `ch_valid`, `ch_done`, `scan_done`, `cfg_err` = 0.
  - FSM in IDLE.
- FSM states: IDLE, BREAK, DWELL.
- IDLE:
  - `mux_config` = 0.
  - On `start` with `stop` low, latch `first_ch`, `last_ch`, `dwell`, `bbm`, `continuous`, `test_sel` into shadow registers.
  - Inputs are ignored after latching until the block returns to IDLE.
- Range check at start (scan mode only):
  - The range is illegal if `last_ch` > 24 or `first_ch` > `last_ch`.
  - On an illegal range, `cfg_err` pulses and the FSM stays in IDLE.
- Next state from IDLE on a legal start: BREAK if `bbm` ≠ 0, otherwise DWELL. The current channel is set to `first_ch`.
- BREAK:
  - `mux_config` = 5'd25, which the encoder decodes to all switches open.
  - Holds for exactly `bbm` cycles, then goes to DWELL.
- DWELL, scan mode:
  - `mux_config` = current channel and `ch_valid` = 1 for exactly max(`dwell`,1) cycles.
  - `ch_done` pulses on the last of those cycles.
- End of a channel's dwell, scan mode:
  - If the channel ≠ `last_ch`: increment the channel, then go to BREAK, or straight to DWELL if `bbm` = 0.
  - If the channel = `last_ch` and `continuous` = 1: wrap to `first_ch` via the same path.
  - If the channel = `last_ch` and `continuous` = 0: pulse `scan_done` and go to IDLE.
- Test mode (`test_sel` = 10 or 11):
  - Range is not checked.
  - One BREAK interval (if `bbm` ≠ 0) precedes DWELL.
  - DWELL then holds code 30 or 31 with `ch_valid` = 1 indefinitely, and the dwell counter is frozen.
  - `ch_done` and `scan_done` are never asserted.
- `stop`:
  - From any non-IDLE state, the next cycle is IDLE with `mux_config` = 0, `busy` = 0, `ch_valid` = 0.
  - No `ch_done` or `scan_done` pulse is issued on the stop cycle.
- `start` and `stop` asserted together in IDLE: `stop` wins and no scan starts.
- `start` while busy: ignored.
- Arithmetic: the dwell counter is a DWELL_W-bit down-counter and the BBM counter is 3 bits. There is no overflow, because both are loaded and not accumulated.
- `mux_config` never takes values 26–29.

## Timing
- Start latency: `start` is sampled at edge N.
  - At N+1: `busy` = 1, and `mux_config` = 25 (BBM) or `first_ch` (no BBM).
- Channel period is `bbm` + max(`dwell`,1) cycles.
- With `bbm` = 0, `mux_config` changes directly from one channel to the next, with no gap cycle.
- `scan_done` is asserted in the same cycle as the last `ch_done`.
  - The following cycle is IDLE: `mux_config` = 0, `busy` = 0.
- Reset mid-scan: all outputs go to their reset values immediately (asynchronous), and the FSM restarts in IDLE after reset release.

## Configuration
- Macro: `TAXEL_SCAN_BBM_EN`.
- Defined: BREAK state present. `bbm` is honoured as described above.
- Undefined:
  - BREAK state and its counter are not synthesised, and the `bbm` port is ignored.
  - Transitions that would enter BREAK go directly to DWELL.
  - Code 25 is never emitted.

## Test plan
- Reset check: hold `rst_n` low mid-scan, with `mux_config` = 7 → outputs immediately become `mux_config` = 0 and `busy`/`ch_valid`/`ch_done`/`scan_done`/`cfg_err` = 0, with no clock edge required; FSM is in IDLE after release.
- Basic scan: `first_ch` = 3, `last_ch` = 5, `dwell` = 4, `bbm` = 2, `continuous` = 0 → `mux_config` sequence 25,25,3×4,25,25,4×4,25,25,5×4, then 0.
  - `ch_done` on cycles 6, 12 and 18 after start.
  - `scan_done` coincident with the third `ch_done`.
- Zero values: `dwell` = 0, `bbm` = 0, range 24..24 → one cycle with `mux_config` = 24, `ch_done` and `scan_done` pulse in that cycle, then IDLE.
- Illegal range: `first_ch` = 10, `last_ch` = 9 → `cfg_err` pulse one cycle after start, `busy` stays 0. Repeat with `last_ch` = 25 → same result.
- Continuous and stop:
  - Range 0..1, `dwell` = 2, `continuous` = 1 → `mux_config` 0,0,1,1,0,0,… with no `scan_done`.
  - Assert `stop` → `mux_config` = 0 and `busy` = 0 the next cycle, with no pulses.
- Test mode: `test_sel` = 11, `bbm` = 1 → `mux_config` 25 then 31 held for 100 cycles with `ch_valid` = 1.
  - Then assert `stop` together with `start` → IDLE, and no restart after it.
